// File: rtl/vec_response_capture.sv
// Response capture block: DEPTH-entry FIFO of 8-bit response vectors with a saturating vector counter.
// Define VEC_RESPONSE_MISR_EN to build the 16-bit MISR signature; without it, signature is tied to zero.
module vec_response_capture #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_resp,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  input  logic        flush,
  input  logic        sig_clear,
  output logic [15:0] vec_count,
  output logic [15:0] signature,
  output logic [3:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LVL_FULL = 4'(DEPTH);
  localparam logic [3:0] LVL_LAST = 4'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          wr_en;
  logic          rd_en;
  logic          count_en;

  // Ready comes only from registered state; rst_n gating holds it low while in reset.
  assign in_ready  = rst_n && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = mem[rd_ptr];

  // flush wins over any same-cycle transfer, so neither pointer nor storage moves.
  assign wr_en    = in_valid && in_ready && !flush;
  assign rd_en    = out_valid && out_ready && !flush;
  assign count_en = wr_en && !sig_clear;

  // NOTE: storage has no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_resp;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case (state)
        EMPTY: begin
          if (wr_en) begin
            state <= PARTIAL;
            level <= 4'd1;
          end
        end
        PARTIAL: begin
          if (wr_en && !rd_en) begin
            level <= level + 4'd1;
            if (level == LVL_LAST) state <= FULL;
          end else if (rd_en && !wr_en) begin
            level <= level - 4'd1;
            if (level == 4'd1) state <= EMPTY;
          end
        end
        FULL: begin
          if (rd_en) begin
            state <= PARTIAL;
            level <= LVL_LAST;
          end
        end
        default: begin
          state <= EMPTY;
          level <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
    end else if (sig_clear) begin
      vec_count <= '0;
    end else if (count_en && (vec_count != 16'hFFFF)) begin
      vec_count <= vec_count + 16'd1;
    end
  end

`ifdef VEC_RESPONSE_MISR_EN
  logic [15:0] misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr <= '0;
    end else if (sig_clear) begin
      misr <= '0;
    end else if (count_en) begin
      misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {8'h00, in_resp};
    end
  end

  assign signature = misr;
`else
  assign signature = 16'h0000;
`endif

  // Occupancy register is authoritative; it is bounded by DEPTH through the FULL state.
  logic unused_ok;
  assign unused_ok = (level == LVL_FULL);

endmodule

// File: tb/tb_vec_response_capture.sv
// Self-checking bench for vec_response_capture: directed table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_vec_response_capture;

  localparam int DEPTH = 4;
`ifdef VEC_RESPONSE_MISR_EN
  localparam bit MISR_EN = 1'b1;
`else
  localparam bit MISR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_resp;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        flush;
  logic        sig_clear;
  logic [15:0] vec_count;
  logic [15:0] signature;
  logic [3:0]  level;

  vec_response_capture #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_resp   (in_resp),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .sig_clear (sig_clear),
    .vec_count (vec_count),
    .signature (signature),
    .level     (level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain queue plus counter/signature arithmetic.
  logic [7:0]  mq[$];
  logic [15:0] m_count;
  logic [15:0] m_sig;

  typedef struct {
    logic        iv;
    logic [7:0]  resp;
    logic        ordy;
    logic        fl;
    logic        sc;
    logic        ev;
    logic [7:0]  ed;
    logic [3:0]  el;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_count = '0;
    m_sig   = '0;
  endtask

  task automatic model_step();
    bit ready, push, pop;
    ready = (mq.size() != DEPTH);
    push  = in_valid && ready;
    pop   = (mq.size() != 0) && out_ready;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(in_resp);
    end
    if (sig_clear) begin
      m_count = '0;
      m_sig   = '0;
    end else if (push && !flush) begin
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (MISR_EN)
        m_sig = ((m_sig << 1) ^ (m_sig[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, in_resp};
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] resp, input logic ordy,
                       input logic fl, input logic sc);
    in_valid  = iv;
    in_resp   = resp;
    out_ready = ordy;
    flush     = fl;
    sig_clear = sc;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"}, 32'(level), 32'(mq.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
    check({tag, ".vec_count"}, 32'(vec_count), 32'(m_count));
    check({tag, ".signature"}, 32'(signature), 32'(m_sig));
    if (mq.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
  endtask

  initial begin
    logic [15:0] sig_before;

    //             iv  resp   or  fl  sc   ev  ed     el  er  ec
    tbl[0]  = '{1, 8'hA5, 0, 0, 0, 1, 8'hA5, 1, 1, 16'd1};
    tbl[1]  = '{0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 16'd1};
    tbl[2]  = '{1, 8'h01, 0, 0, 0, 1, 8'h01, 1, 1, 16'd2};
    tbl[3]  = '{1, 8'h02, 0, 0, 0, 1, 8'h01, 2, 1, 16'd3};
    tbl[4]  = '{1, 8'h03, 0, 0, 0, 1, 8'h01, 3, 1, 16'd4};
    tbl[5]  = '{1, 8'h04, 0, 0, 0, 1, 8'h01, 4, 0, 16'd5};
    tbl[6]  = '{1, 8'h05, 0, 0, 0, 1, 8'h01, 4, 0, 16'd5};
    tbl[7]  = '{1, 8'h05, 1, 0, 0, 1, 8'h02, 3, 1, 16'd5};
    tbl[8]  = '{1, 8'h05, 0, 0, 0, 1, 8'h02, 4, 0, 16'd6};
    tbl[9]  = '{0, 8'h00, 1, 0, 0, 1, 8'h03, 3, 1, 16'd6};
    tbl[10] = '{0, 8'h00, 1, 0, 0, 1, 8'h04, 2, 1, 16'd6};
    tbl[11] = '{1, 8'h06, 1, 0, 0, 1, 8'h05, 2, 1, 16'd7};
    tbl[12] = '{1, 8'h07, 1, 0, 0, 1, 8'h06, 2, 1, 16'd8};
    tbl[13] = '{0, 8'h00, 1, 0, 0, 1, 8'h07, 1, 1, 16'd8};
    tbl[14] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 16'd8};
    tbl[15] = '{1, 8'h09, 0, 0, 1, 1, 8'h09, 1, 1, 16'd0};
    tbl[16] = '{1, 8'h03, 0, 1, 0, 0, 8'h00, 0, 1, 16'd0};

    rst_n = 1'b0; in_valid = 0; in_resp = 0; out_ready = 0; flush = 0; sig_clear = 0;
    model_reset();
    #2;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.level", 32'(level), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'd1);
    check("post_rst.out_valid", 32'(out_valid), 32'd0);
    check("post_rst.level", 32'(level), 32'd0);
    check("post_rst.vec_count", 32'(vec_count), 32'd0);
    check("post_rst.signature", 32'(signature), 32'h0000);

    // MISR sequence straight out of reset.
    cycle(1, 8'h01, 0, 0, 0);
    check("misr1.signature", 32'(signature), MISR_EN ? 32'h0001 : 32'h0000);
    cycle(1, 8'h80, 0, 0, 0);
    check("misr2.signature", 32'(signature), MISR_EN ? 32'h0082 : 32'h0000);
    check("misr2.vec_count", 32'(vec_count), 32'd2);
    cycle(0, 8'h00, 0, 0, 1);
    check("sigclr.signature", 32'(signature), 32'h0000);
    check("sigclr.vec_count", 32'(vec_count), 32'd0);
    check("sigclr.level", 32'(level), 32'd2);
    cycle(0, 8'h00, 0, 1, 0);
    check("flush0.level", 32'(level), 32'd0);

    for (int i = 0; i < 17; i++) begin
      string tag;
      cycle(tbl[i].iv, tbl[i].resp, tbl[i].ordy, tbl[i].fl, tbl[i].sc);
      tag = $sformatf("tbl%0d", i);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(tbl[i].ev));
      check({tag, ".level"}, 32'(level), 32'(tbl[i].el));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(tbl[i].er));
      check({tag, ".vec_count"}, 32'(vec_count), 32'(tbl[i].ec));
      if (tbl[i].ev) check({tag, ".out_data"}, 32'(out_data), 32'(tbl[i].ed));
    end

    // Flush at level 3 with a coincident push.
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    check("pre_flush.level", 32'(level), 32'd3);
    check_model("pre_flush");
    sig_before = m_sig;
    cycle(1, 8'h44, 0, 1, 0);
    check("flush.level", 32'(level), 32'd0);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    check("flush.signature", 32'(signature), 32'(sig_before));
    check("flush.vec_count", 32'(vec_count), 32'd3);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
            ($urandom % 40) == 0, ($urandom % 60) == 0);
      check_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-run.
    cycle(1, 8'h5A, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.level", 32'(level), 32'd0);
    check("async_rst.out_valid", 32'(out_valid), 32'd0);
    check("async_rst.in_ready", 32'(in_ready), 32'd0);
    check("async_rst.vec_count", 32'(vec_count), 32'd0);
    check("async_rst.signature", 32'(signature), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
